// File: rtl/eb1_uart_pkg.sv
// Shared UART definitions for the eb1 transmitter and receiver:
// state encodings, data/divisor widths and the divisor clamp helper.
package eb1_uart_pkg;
    localparam int UART_DATA_W = 8;
    localparam int UART_DIV_W  = 16;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // A divisor of zero would never end a bit; run it as one clock per bit.
    function automatic logic [UART_DIV_W-1:0] clamp_div(input logic [UART_DIV_W-1:0] d);
        return (d == '0) ? UART_DIV_W'(1) : d;
    endfunction
endpackage

// File: rtl/eb1_uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter. Pushes while full are dropped;
// the full flag is registered from the post-edge occupancy.
module eb1_uart_tx_fifo
    import eb1_uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic [UART_DATA_W-1:0] i_din,
    input  logic                   i_pop,
    output logic [UART_DATA_W-1:0] o_dout,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [UART_DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wr, r_rd;
    logic [AW:0]            r_count, w_count_nxt;
    logic                   r_full;
    logic                   w_push, w_pop;

    assign w_push = i_push && !r_full;
    assign w_pop  = i_pop && (r_count != '0);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + 1'b1;
        else if (!w_push && w_pop)
            w_count_nxt = r_count - 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == (AW+1)'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr] <= i_din;
    end

    assign o_dout  = r_mem[r_rd];
    assign o_full  = r_full;
    assign o_empty = (r_count == '0);
endmodule

// File: rtl/eb1_uart_tx_prog.sv
// Buffered 8N1 UART transmitter with a divisor latched at each frame start.
// Define EB1_UART_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD).
module eb1_uart_tx_prog
    import eb1_uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic                   i_Clock,
    input  logic                   rst_i,
    input  logic [UART_DIV_W-1:0]  CLKS_PER_BIT,
    input  logic                   i_Tx_DV,
    input  logic [UART_DATA_W-1:0] i_Tx_Byte,
    output logic                   o_Tx_Ready,
    output logic                   o_Tx_Serial,
    output logic                   o_Tx_Active,
    output logic                   o_Tx_Done
);
    logic [2:0]             r_state, w_next_state;
    logic [UART_DIV_W-1:0]  r_cnt, w_cnt_nxt, r_n;
    logic [2:0]             r_bit, w_bit_nxt;
    logic [UART_DATA_W-1:0] r_data, w_head;
    logic                   r_serial, w_serial_nxt;
    logic                   r_active, w_active_nxt;
    logic                   r_done, w_done_nxt;
    logic                   w_pop, w_full, w_empty;
    logic                   w_bit_end, w_after_data;
    logic [2:0]             w_state_after_data;

    eb1_uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk  (i_Clock),
        .i_rst  (rst_i),
        .i_push (i_Tx_DV),
        .i_din  (i_Tx_Byte),
        .i_pop  (w_pop),
        .o_dout (w_head),
        .o_full (w_full),
        .o_empty(w_empty)
    );

`ifdef EB1_UART_TX_PARITY_EN
    assign w_after_data       = (PARITY_ODD != 0) ? ~^r_data : ^r_data;
    assign w_state_after_data = S_PARITY;
`else
    assign w_after_data       = 1'b1;
    assign w_state_after_data = S_STOP;
`endif

    assign w_bit_end = (r_cnt == r_n - UART_DIV_W'(1));

    always_ff @(posedge i_Clock or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_n      <= UART_DIV_W'(1);
            r_bit    <= '0;
            r_data   <= '0;
            r_serial <= 1'b1;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_cnt    <= w_cnt_nxt;
            r_bit    <= w_bit_nxt;
            r_serial <= w_serial_nxt;
            r_active <= w_active_nxt;
            r_done   <= w_done_nxt;
            if (w_pop) begin
                r_data <= w_head;
                r_n    <= clamp_div(CLKS_PER_BIT);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (!w_empty) w_next_state = S_START;
            S_START:  if (w_bit_end) w_next_state = S_DATA;
            S_DATA:   if (w_bit_end && r_bit == 3'd7) w_next_state = w_state_after_data;
`ifdef EB1_UART_TX_PARITY_EN
            S_PARITY: if (w_bit_end) w_next_state = S_STOP;
`endif
            S_STOP:   if (w_bit_end) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Values the output registers take at the next edge.
    always_comb begin
        w_pop        = 1'b0;
        w_serial_nxt = r_serial;
        w_active_nxt = r_active;
        w_done_nxt   = 1'b0;
        w_bit_nxt    = r_bit;
        w_cnt_nxt    = w_bit_end ? '0 : r_cnt + UART_DIV_W'(1);
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt    = '0;
                w_bit_nxt    = '0;
                w_pop        = !w_empty;
                w_serial_nxt = w_empty;
                w_active_nxt = !w_empty;
            end
            S_START:
                if (w_bit_end) w_serial_nxt = r_data[0];
            S_DATA:
                if (w_bit_end) begin
                    if (r_bit == 3'd7) begin
                        w_serial_nxt = w_after_data;
                    end else begin
                        w_bit_nxt    = r_bit + 3'd1;
                        w_serial_nxt = r_data[r_bit + 3'd1];
                    end
                end
`ifdef EB1_UART_TX_PARITY_EN
            S_PARITY:
                if (w_bit_end) w_serial_nxt = 1'b1;
`endif
            S_STOP:
                if (w_bit_end) begin
                    w_serial_nxt = 1'b1;
                    w_active_nxt = 1'b0;
                    w_done_nxt   = 1'b1;
                end
            default: begin
                w_cnt_nxt    = '0;
                w_serial_nxt = 1'b1;
                w_active_nxt = 1'b0;
            end
        endcase
    end

    assign o_Tx_Ready  = !w_full;
    assign o_Tx_Serial = r_serial;
    assign o_Tx_Active = r_active;
    assign o_Tx_Done   = r_done;
endmodule
